// File: rtl/aes_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// aes_sub_bytes_seq
//   Iterative forward-SubBytes engine for the AES encrypt datapath. It takes
//   a 128-bit state, applies the forward S-box to LANES bytes per cycle, and
//   presents the substituted state once all 16 bytes are done. The S-box is
//   computed arithmetically (GF(2^8) inverse followed by the affine map), so
//   no lookup ROM is needed.
//
// Parameters
//   LANES      S-box instances / bytes substituted per cycle (1,2,4,8,16)
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous active-high reset
//   in_valid   in   1    in_data is valid
//   in_ready   out  1    block is idle and can accept a new state
//   in_data    in   128  input state, byte k = in_data[127-8k -: 8]
//   out_valid  out  1    out_data holds a completed result
//   out_ready  in   1    downstream accepts out_data
//   out_data   out  128  substituted state, same byte order as in_data
// ---------------------------------------------------------------------------
module aes_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int GROUPS = 16 / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] LAST_GRP = CW'(GROUPS - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [127:0]  work;
  logic [127:0]  work_next;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (shift-and-add).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 = a^2 * a^4 * ... * a^128; this also yields inv(0)=0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    logic [7:0] b;
    v = gf_inv(a);
    for (int i = 0; i < 8; i++) begin
      b[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8];
    end
    return b ^ 8'h63;
  endfunction

  // Substitute the current group of LANES bytes; all other bytes pass through.
  always_comb begin
    work_next = work;
    for (int l = 0; l < LANES; l++) begin
      work_next[127 - 8 * (int'(cnt) * LANES + l) -: 8] =
        sbox(work[127 - 8 * (int'(cnt) * LANES + l) -: 8]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (cnt == LAST_GRP) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // in_data is only captured on the accept edge; later changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_data;
            cnt  <= '0;
          end
        end
        BUSY: begin
          work <= work_next;
          cnt  <= (cnt == LAST_GRP) ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = work;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_sub_bytes_seq
//   Self-checking bench for aes_sub_bytes_seq. Five instances (LANES = 1, 2,
//   4, 8, 16) share the inputs; the LANES=4 instance is the main subject and
//   the others are compared on the FIPS-197 vector and its latency. Expected
//   values come from the published forward S-box table and literal vectors.
// ---------------------------------------------------------------------------
module tb_aes_sub_bytes_seq;

  localparam int M = 2;

  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  logic [4:0]   ir;
  logic [4:0]   ov;
  logic [127:0] od [5];

  logic [7:0]   sbox_tab [256];
  logic [7:0]   inv_tab  [256];

  int checks;
  int failures;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_sub_bytes_seq #(.LANES(1 << g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (ir[g]),
      .in_data  (in_data),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .out_data (od[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] ref_sub(input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127 - 8 * k -: 8] = sbox_tab[d[127 - 8 * k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127 - 8 * k -: 8] = inv_tab[d[127 - 8 * k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the main instance to be idle, then present d for
  // exactly one accept edge and scramble in_data afterwards.
  task automatic apply_stimulus(input logic [127:0] d);
    int n;
    n = 0;
    while (!ir[M] && n < 40) begin
      tick();
      n++;
    end
    check_output("in_ready_before_accept", 128'(ir[M]), 128'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = rand128();
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = 0;
    while (!ov[M] && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  // Full transaction on the main instance with `hold` cycles of backpressure.
  task automatic do_block(input logic [127:0] d, input string tag, input int hold,
                          output logic [127:0] got);
    int cyc;
    apply_stimulus(d);
    wait_valid(40, cyc);
    check_output({tag, "_latency"}, 128'(cyc), 128'd4);
    check_output({tag, "_data"}, od[M], ref_sub(d));
    got = od[M];
    for (int h = 0; h < hold; h++) begin
      tick();
      check_output({tag, "_hold"}, od[M], got);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output({tag, "_idle_after"}, 128'(ir[M]), 128'd1);
  endtask

  initial begin
    int lat [5];
    logic [127:0] cap [5];
    logic [127:0] got;
    logic [127:0] d;
    logic [127:0] res [$];
    int acc [2];
    int nacc;
    int cyc;

    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) begin
      sbox_tab[i] = SBOX_FLAT[2047 - 8 * i -: 8];
      inv_tab[SBOX_FLAT[2047 - 8 * i -: 8]] = 8'(i);
    end

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check_output("reset_in_ready", 128'(ir), 128'h1F);
    check_output("reset_out_valid", 128'(ov), 128'h0);
    check_output("reset_out_data", od[M], 128'h0);
    rst = 1'b0;
    tick();

    // FIPS-197 round-1 vector through every LANES value at once.
    in_valid = 1'b1;
    in_data  = FIPS_IN;
    tick();
    in_valid = 1'b0;
    in_data  = rand128();
    for (int g = 0; g < 5; g++) lat[g] = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      for (int g = 0; g < 5; g++) begin
        if (ov[g] && lat[g] == 0) begin
          lat[g] = c;
          cap[g] = od[g];
        end
      end
    end
    for (int g = 0; g < 5; g++) begin
      check_output($sformatf("fips_lat_lanes%0d", 1 << g), 128'(lat[g]), 128'(16 >> g));
      check_output($sformatf("fips_data_lanes%0d", 1 << g), cap[g], FIPS_OUT);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("fips_all_idle", 128'(ir), 128'h1F);

    do_block({32'h0001_53FF, 96'h0}, "single_byte", 0, got);
    check_output("single_byte_literal", got, {32'h637C_ED16, {12{8'h63}}});

    // Exhaustive: block b carries bytes 16b .. 16b+15.
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) d[127 - 8 * k -: 8] = 8'(16 * b + k);
      do_block(d, $sformatf("exh%0d", b), 0, got);
      check_output($sformatf("exh%0d_inverse", b), ref_inv(got), d);
    end

    for (int n = 0; n < 8; n++) begin
      do_block(rand128(), $sformatf("rand%0d", n), int'($urandom_range(0, 3)), got);
    end

    // Backpressure with a stray in_valid pulse while DONE.
    d = rand128();
    apply_stimulus(d);
    wait_valid(40, cyc);
    check_output("bp_latency", 128'(cyc), 128'd4);
    got = od[M];
    check_output("bp_data", got, ref_sub(d));
    for (int h = 0; h < 10; h++) begin
      in_valid = (h == 3);
      in_data  = rand128();
      tick();
      check_output("bp_stable", od[M], got);
      check_output("bp_in_ready", 128'(ir[M]), 128'd0);
      check_output("bp_out_valid", 128'(ov[M]), 128'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("bp_in_ready_after", 128'(ir[M]), 128'd1);
    check_output("bp_out_valid_after", 128'(ov[M]), 128'd0);

    // Back-to-back: in_valid held, out_ready tied high.
    d = rand128();
    got = rand128();
    res.delete();
    nacc = 0;
    acc[0] = 0;
    acc[1] = 0;
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    for (int t = 0; t < 30; t++) begin
      if (in_valid && ir[M]) begin
        acc[nacc] = t;
        nacc++;
      end
      if (ov[M]) res.push_back(od[M]);
      tick();
      if (nacc == 1) in_data = got;
      if (nacc == 2) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    check_output("b2b_accepts", 128'(nacc), 128'd2);
    check_output("b2b_spacing", 128'(acc[1] - acc[0]), 128'd6);
    check_output("b2b_count", 128'(res.size()), 128'd2);
    if (res.size() == 2) begin
      check_output("b2b_first", res[0], ref_sub(d));
      check_output("b2b_second", res[1], ref_sub(got));
    end

    // Reset two cycles into BUSY discards the block.
    tick();
    apply_stimulus(rand128());
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_output("mid_rst_out_valid", 128'(ov[M]), 128'd0);
    check_output("mid_rst_out_data", od[M], 128'h0);
    check_output("mid_rst_in_ready", 128'(ir[M]), 128'd1);
    tick();
    check_output("mid_rst_held_data", od[M], 128'h0);
    check_output("mid_rst_held_ready", 128'(ir[M]), 128'd1);
    rst = 1'b0;
    cyc = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (ov[M]) cyc++;
    end
    check_output("mid_rst_no_stale", 128'(cyc), 128'd0);
    do_block(rand128(), "post_rst", 1, got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
